// File: rtl/shift_seq_pkg.sv
// Shared definitions for the logarithmic shifter sequencing controller.
//   - WIDTH / STAGES / AMT_W : datapath width, stage count, shift-amount width
//   - STAGE_WEIGHT           : shift distance of stage k (stage 0 shifts by 16)
//   - DIR_LEFT / DIR_RIGHT   : encodings of the DIR input
//   - state_e                : controller FSM states
//   - next_active_stage()    : stage-skip helper used by the SKIP_ZERO_STAGE_EN build
package shift_seq_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 5;
  localparam int unsigned AMT_W  = 5;

  localparam int unsigned STAGE_WEIGHT [STAGES] = '{16, 8, 4, 2, 1};

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // StK encodes as K+1 so the stage index is recoverable from the state value.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    St0    = 3'd1,
    St1    = 3'd2,
    St2    = 3'd3,
    St3    = 3'd4,
    St4    = 3'd5,
    StFin  = 3'd6
  } state_e;

  // First stage index >= first whose amount bit is set, as a state; StFin if none.
  function automatic state_e next_active_stage(input logic [AMT_W-1:0] amt,
                                               input int unsigned first);
    state_e nxt;
    nxt = StFin;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k >= int'(first) && amt[STAGES-1-k]) nxt = state_e'(3'(k + 1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/shift_stage_dec.sv
// Per-stage select decoder for one shift stage.
// Ports:
//   active          in  : this stage owns the result bus this cycle
//   amt_bit         in  : shift-amount bit belonging to this stage
//   dir             in  : DIR_LEFT / DIR_RIGHT
//   l_shift/r_shift/no_shift      out : one-hot direction select
//   left_not/right_not/old_not    out : complements of the selects
//   shift_en/shift_en_not         out : bus enable and its complement
// Inactive stages park on no_shift so every stage always has exactly one select high.
module shift_stage_dec
  import shift_seq_pkg::*;
(
  input  logic active,
  input  logic amt_bit,
  input  logic dir,
  output logic l_shift,
  output logic r_shift,
  output logic no_shift,
  output logic left_not,
  output logic right_not,
  output logic old_not,
  output logic shift_en,
  output logic shift_en_not
);

  always_comb begin
    l_shift      = active & amt_bit & (dir == DIR_LEFT);
    r_shift      = active & amt_bit & (dir == DIR_RIGHT);
    no_shift     = ~(l_shift | r_shift);
    left_not     = ~l_shift;
    right_not    = ~r_shift;
    old_not      = ~no_shift;
    shift_en     = active;
    shift_en_not = ~active;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the 32-bit 16/8/4/2/1 logarithmic shifter.
// Holds the operand register feeding every stage, enables one stage per cycle onto
// the shared result bus, captures the bus back, and returns the result with DONE.
// Ports:
//   CLK, RST (async, active-high), START, DIR (1=left), AMT[4:0], DIN, BUS_IN
//   STAGE_IN                        : operand register to all stage inputs
//   L_SHIFT/R_SHIFT/NO_SHIFT        : per-stage one-hot select
//   LEFT_NOT/RIGHT_NOT/OLD_NOT      : their complements
//   shift_en/shift_en_not           : per-stage bus enable (one-hot or zero) and complement
//   BUSY, DONE (one-cycle pulse), DOUT (held result)
// Parameter CAPTURE_INV inverts BUS_IN on capture for an odd-inverting stage path.
// Build option: define SKIP_ZERO_STAGE_EN to skip stages whose amount bit is 0
// (latency popcount(AMT)+1); otherwise all five stages are walked (latency 6).
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter bit CAPTURE_INV = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              DIR,
  input  logic [AMT_W-1:0]  AMT,
  input  logic [WIDTH-1:0]  DIN,
  input  logic [WIDTH-1:0]  BUS_IN,
  output logic [WIDTH-1:0]  STAGE_IN,
  output logic [STAGES-1:0] L_SHIFT,
  output logic [STAGES-1:0] R_SHIFT,
  output logic [STAGES-1:0] NO_SHIFT,
  output logic [STAGES-1:0] LEFT_NOT,
  output logic [STAGES-1:0] RIGHT_NOT,
  output logic [STAGES-1:0] OLD_NOT,
  output logic [STAGES-1:0] shift_en,
  output logic [STAGES-1:0] shift_en_not,
  output logic              BUSY,
  output logic              DONE,
  output logic [WIDTH-1:0]  DOUT
);

  state_e             state_q, state_d;
  logic [STAGES-1:0]  stage_act_q, stage_act_d;
  logic [AMT_W-1:0]   amt_q;
  logic               dir_q;
  logic [WIDTH-1:0]   stage_in_q;
  logic [WIDTH-1:0]   dout_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   capture;

  always_comb begin
    state_d = state_q;
    capture = BUS_IN ^ {WIDTH{CAPTURE_INV}};
    unique case (state_q)
      StIdle: begin
        if (START) begin
`ifdef SKIP_ZERO_STAGE_EN
          state_d = next_active_stage(AMT, 0);
`else
          state_d = St0;
`endif
        end
      end
      St0, St1, St2, St3, St4: begin
`ifdef SKIP_ZERO_STAGE_EN
        // State value K+1 is also the index of the next stage to consider.
        state_d = next_active_stage(amt_q, 32'(state_q));
`else
        state_d = (state_q == St4) ? StFin : state_e'(state_q + 3'd1);
`endif
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Enables come straight from a one-hot register, so no decode glitch can
    // briefly turn on two stage drivers during a state change.
    for (int k = 0; k < STAGES; k++) begin
      stage_act_d[k] = (state_d == state_e'(3'(k + 1)));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      stage_act_q <= '0;
      amt_q       <= '0;
      dir_q       <= 1'b0;
      stage_in_q  <= '0;
      dout_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_act_q <= stage_act_d;
      busy_q      <= (state_d != StIdle) && (state_d != StFin);
      done_q      <= (state_d == StFin);
      unique case (state_q)
        StIdle: begin
          if (START) begin
            stage_in_q <= DIN;
            amt_q      <= AMT;
            dir_q      <= DIR;
            // Only reachable with stage skipping and AMT=0.
            if (state_d == StFin) dout_q <= DIN;
          end
        end
        St0, St1, St2, St3, St4: begin
          stage_in_q <= capture;
          // Load DOUT on entry to FIN so it is valid alongside DONE.
          if (state_d == StFin) dout_q <= capture;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_stage_dec u_dec (
      .active       (stage_act_q[k]),
      .amt_bit      (amt_q[STAGES-1-k]),
      .dir          (dir_q),
      .l_shift      (L_SHIFT[k]),
      .r_shift      (R_SHIFT[k]),
      .no_shift     (NO_SHIFT[k]),
      .left_not     (LEFT_NOT[k]),
      .right_not    (RIGHT_NOT[k]),
      .old_not      (OLD_NOT[k]),
      .shift_en     (shift_en[k]),
      .shift_en_not (shift_en_not[k])
    );
  end

  assign STAGE_IN = stage_in_q;
  assign DOUT     = dout_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural model of the five shift stages
// driving BUS_IN. Honours SKIP_ZERO_STAGE_EN for the expected stage walk and latency.
`timescale 1ns/1ps
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

`ifdef SKIP_ZERO_STAGE_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, START, DIR;
  logic [4:0]  AMT;
  logic [31:0] DIN, BUS_IN, STAGE_IN, DOUT;
  logic [4:0]  L_SHIFT, R_SHIFT, NO_SHIFT, LEFT_NOT, RIGHT_NOT, OLD_NOT;
  logic [4:0]  shift_en, shift_en_not;
  logic        BUSY, DONE;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  shift_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .DIR(DIR), .AMT(AMT), .DIN(DIN),
    .BUS_IN(BUS_IN), .STAGE_IN(STAGE_IN), .L_SHIFT(L_SHIFT), .R_SHIFT(R_SHIFT),
    .NO_SHIFT(NO_SHIFT), .LEFT_NOT(LEFT_NOT), .RIGHT_NOT(RIGHT_NOT), .OLD_NOT(OLD_NOT),
    .shift_en(shift_en), .shift_en_not(shift_en_not), .BUSY(BUSY), .DONE(DONE), .DOUT(DOUT)
  );

  // Behavioural shift stages; a released bus reads as zero in two-state simulation.
  always_comb begin
    BUS_IN = '0;
    for (int k = 0; k < 5; k++) begin
      if (shift_en[k]) begin
        if (L_SHIFT[k])      BUS_IN = STAGE_IN << STAGE_WEIGHT[k];
        else if (R_SHIFT[k]) BUS_IN = STAGE_IN >> STAGE_WEIGHT[k];
        else                 BUS_IN = STAGE_IN;
      end
    end
  end

  // Select/enable invariants, every cycle.
  always @(negedge CLK) begin
    vectors++;
    if (((L_SHIFT & R_SHIFT) | (L_SHIFT & NO_SHIFT) | (R_SHIFT & NO_SHIFT)) !== 5'h00 ||
        (L_SHIFT | R_SHIFT | NO_SHIFT) !== 5'h1F || LEFT_NOT !== ~L_SHIFT ||
        RIGHT_NOT !== ~R_SHIFT || OLD_NOT !== ~NO_SHIFT || $countones(shift_en) > 1 ||
        shift_en_not !== ~shift_en) begin
      miscompares++;
      $display("FAIL invariant: L=%b R=%b NO=%b Ln=%b Rn=%b On=%b en=%b en_n=%b",
               L_SHIFT, R_SHIFT, NO_SHIFT, LEFT_NOT, RIGHT_NOT, OLD_NOT, shift_en,
               shift_en_not);
    end
  end

  localparam int NV = 6;
  localparam logic [31:0] V_DIN [NV] = '{32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF,
                                         32'h0000_0001, 32'hF0F0_1234, 32'h0000_ABCD};
  localparam logic [4:0]  V_AMT [NV] = '{5'd17, 5'd31, 5'd0, 5'd4, 5'd13, 5'd10};
  localparam logic        V_DIR [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] V_EXP [NV] = '{32'h0002_0000, 32'h0000_0001, 32'hDEAD_BEEF,
                                         32'h0000_0010, 32'h0007_8780, 32'h02AF_3400};

  logic [4:0]  en_tr [16];
  logic [4:0]  l_tr  [16];
  logic [4:0]  r_tr  [16];
  logic        busy_tr [16];
  int          done_cyc;
  logic [31:0] res;
  logic        busy_at_done;
  logic        done_after;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Accept at edge 0, record cycles 1.. until DONE, then step back to IDLE.
  task automatic run_op(input logic [31:0] din, input logic [4:0] amt, input logic dir);
    DIN = din; AMT = amt; DIR = dir; START = 1'b1;
    tick;
    START = 1'b0;
    done_cyc = 0; res = '0; busy_at_done = 1'b1;
    for (int c = 1; c < 16; c++) begin
      en_tr[c] = shift_en; l_tr[c] = L_SHIFT; r_tr[c] = R_SHIFT; busy_tr[c] = BUSY;
      if (DONE) begin
        done_cyc = c; res = DOUT; busy_at_done = BUSY;
        break;
      end
      tick;
    end
    tick;
    done_after = DONE;
  endtask

  task automatic test_reset;
    vectors++;
    if (STAGE_IN !== 32'h0 || DOUT !== 32'h0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL reset regs: stage_in=%h dout=%h busy=%b done=%b want 0/0/0/0",
               STAGE_IN, DOUT, BUSY, DONE);
    end
    vectors++;
    if (shift_en !== 5'h00 || shift_en_not !== 5'h1F) begin
      miscompares++;
      $display("FAIL reset enable: en=%b en_n=%b want 00000/11111", shift_en, shift_en_not);
    end
    vectors++;
    if (NO_SHIFT !== 5'h1F || L_SHIFT !== 5'h00 || R_SHIFT !== 5'h00 ||
        LEFT_NOT !== 5'h1F || RIGHT_NOT !== 5'h1F || OLD_NOT !== 5'h00) begin
      miscompares++;
      $display("FAIL reset selects: L=%b R=%b NO=%b Ln=%b Rn=%b On=%b want 0/0/1F/1F/1F/0",
               L_SHIFT, R_SHIFT, NO_SHIFT, LEFT_NOT, RIGHT_NOT, OLD_NOT);
    end
  endtask

  task automatic test_shift_vectors;
    int idx;
    logic [4:0] amt;
    logic sel;
    logic [4:0] exp_l, exp_r;
    for (int v = 0; v < NV; v++) begin
      amt = V_AMT[v];
      run_op(V_DIN[v], amt, V_DIR[v]);
      vectors++;
      if (res !== V_EXP[v]) begin
        miscompares++;
        $display("FAIL vec%0d dout: got %h want %h", v, res, V_EXP[v]);
      end
      idx = 1;
      for (int k = 0; k < 5; k++) begin
        sel = amt[4-k];
        if (SKIP && !sel) continue;
        exp_l = (sel && V_DIR[v])  ? 5'(1 << k) : 5'h00;
        exp_r = (sel && !V_DIR[v]) ? 5'(1 << k) : 5'h00;
        vectors++;
        if (en_tr[idx] !== 5'(1 << k) || l_tr[idx] !== exp_l || r_tr[idx] !== exp_r ||
            busy_tr[idx] !== 1'b1) begin
          miscompares++;
          $display("FAIL vec%0d stage%0d: en=%b L=%b R=%b busy=%b want en=%b L=%b R=%b busy=1",
                   v, k, en_tr[idx], l_tr[idx], r_tr[idx], busy_tr[idx], 5'(1 << k),
                   exp_l, exp_r);
        end
        idx++;
      end
      vectors++;
      if (done_cyc != idx || busy_at_done !== 1'b0 || done_after !== 1'b0) begin
        miscompares++;
        $display("FAIL vec%0d done: cycle=%0d busy=%b next_done=%b want cycle=%0d busy=0 next=0",
                 v, done_cyc, busy_at_done, done_after, idx);
      end
    end
  endtask

  task automatic test_start_held;
    int c;
    DIN = 32'h0000_00F0; AMT = 5'd4; DIR = 1'b1; START = 1'b1;
    tick;
    DIN = 32'h1234_5678; AMT = 5'd8; DIR = 1'b0;
    c = 1;
    while (!DONE && c < 16) begin tick; c++; end
    vectors++;
    if (DONE !== 1'b1 || DOUT !== 32'h0000_0F00) begin
      miscompares++;
      $display("FAIL held first: done=%b dout=%h want 1/00000f00", DONE, DOUT);
    end
    tick;
    vectors++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL held idle: busy=%b done=%b want 0/0", BUSY, DONE);
    end
    tick;
    vectors++;
    if (BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL held second accept: busy=%b want 1", BUSY);
    end
    START = 1'b0;
    c = 1;
    while (!DONE && c < 16) begin tick; c++; end
    vectors++;
    if (DONE !== 1'b1 || DOUT !== 32'h0012_3456) begin
      miscompares++;
      $display("FAIL held second: done=%b dout=%h want 1/00123456", DONE, DOUT);
    end
    tick;
  endtask

  task automatic test_rst_mid;
    int c;
    DIN = 32'h0000_0001; AMT = 5'd7; DIR = 1'b1; START = 1'b1;
    tick;
    START = 1'b0;
    c = 0;
    while (shift_en !== 5'b00100 && c < 16) begin tick; c++; end
    vectors++;
    if (shift_en !== 5'b00100) begin
      miscompares++;
      $display("FAIL rst_mid reach stage2: en=%b want 00100", shift_en);
    end
    #2 RST = 1'b1;
    #1;
    vectors++;
    if (shift_en !== 5'h00 || shift_en_not !== 5'h1F || BUSY !== 1'b0 || DONE !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid async: en=%b en_n=%b busy=%b done=%b want 00000/11111/0/0",
               shift_en, shift_en_not, BUSY, DONE);
    end
    vectors++;
    if (STAGE_IN !== 32'h0 || DOUT !== 32'h0 || NO_SHIFT !== 5'h1F) begin
      miscompares++;
      $display("FAIL rst_mid regs: stage_in=%h dout=%h no=%b want 0/0/11111",
               STAGE_IN, DOUT, NO_SHIFT);
    end
    tick; tick;
    vectors++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid held: done=%b busy=%b want 0/0", DONE, BUSY);
    end
    RST = 1'b0;
    tick;
    run_op(32'h0000_0003, 5'd7, 1'b1);
    vectors++;
    if (res !== 32'h0000_0180 || done_cyc != (SKIP ? 4 : 6)) begin
      miscompares++;
      $display("FAIL rst_mid recover: dout=%h cycle=%0d want 00000180 cycle=%0d",
               res, done_cyc, SKIP ? 4 : 6);
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; DIR = 1'b0; AMT = '0; DIN = '0;
    tick; tick;
    test_reset;
    RST = 1'b0;
    tick;
    test_shift_vectors;
    test_start_held;
    test_rst_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
